multicycle_sequencer: RTL

Multi-cycle instruction sequencer for the RV32I-subset core. It steps each instruction through fetch, decode, execute, memory and writeback over a single shared memory port. It gates the decoder's register-file and data-memory write controls so they take effect only in the correct cycle. It counts retired instructions and traps on an illegal opcode or a memory timeout.

---
 rtl/riscv_seq_pkg.sv | 35 +++
 rtl/mem_wait_timer.sv | 45 ++++
 rtl/multicycle_sequencer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/riscv_seq_pkg.sv
// Shared definitions for the RV32I-subset multi-cycle core.
// Holds the sequencer state encoding, the major opcode constants (shared
// with the control decoder), the MEM_SEL address-source encodings, and a
// helper that classifies opcodes which finish through writeback.
package riscv_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } seq_state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic MEM_SEL_PC   = 1'b0;
    localparam logic MEM_SEL_DATA = 1'b1;

    // Opcodes that skip the data-memory step and go straight to writeback.
    function automatic logic is_wb_op(input logic [6:0] op);
        return (op == OP_ITYPE)  || (op == OP_RTYPE) || (op == OP_LUI) ||
               (op == OP_JALR)   || (op == OP_BRANCH) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait timer.
// Counts cycles a memory request has gone unanswered and flags when the
// count has reached LIMIT-1, i.e. the current cycle is the last one allowed.
// Ports:
//   clk_i      rising-edge clock
//   rst_i      synchronous active-high reset
//   clr_i      clear count to zero (takes priority over en_i)
//   en_i       count one more unanswered cycle
//   expired_o  count has reached LIMIT-1
module mem_wait_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [7:0] LAST = 8'(LIMIT - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Saturating at LAST keeps the flag asserted if the caller lingers.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 8'd0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle instruction sequencer for the RV32I-subset core.
// Steps each instruction through FETCH, DECODE, EXEC, MEM, WB over one
// shared memory port, gates decoder write requests into the right cycle,
// counts retired instructions and traps on illegal opcodes or memory
// timeouts.
// Ports:
//   CLK, RST      clock, synchronous active-high reset
//   RUN           enable, sampled only at instruction boundaries
//   OP_CODE       opcode from the instruction register
//   CRF, CDM      decoder register-file / data-memory write requests
//   MEM_ACK       memory completion (meaningful only while MEM_REQ=1)
//   MEM_REQ/SEL/WE  memory request, address source, write strobe
//   IR_LD, PC_WE, RF_WE  datapath load/commit strobes
//   FAULT         sticky trap flag
//   RETIRED       retired-instruction count (wraps)
module multicycle_sequencer
    import riscv_seq_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             RUN,
    input  logic [6:0]       OP_CODE,
    input  logic             CRF,
    input  logic             CDM,
    input  logic             MEM_ACK,
    output logic             MEM_REQ,
    output logic             MEM_SEL,
    output logic             MEM_WE,
    output logic             IR_LD,
    output logic             PC_WE,
    output logic             RF_WE,
    output logic             FAULT,
    output logic [CNT_W-1:0] RETIRED
);

    seq_state_e       state_q;
    seq_state_e       state_d;
    logic [CNT_W-1:0] retired_q;
    logic [CNT_W-1:0] retired_d;

    logic in_req;
    logic expired;
    logic is_store;

    assign in_req   = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign is_store = (OP_CODE == OP_STORE);

    // Clearing on ack (not only on entry) covers the store case where MEM
    // hands straight over to the next FETCH.
    mem_wait_timer #(
        .LIMIT(TIMEOUT)
    ) u_timer (
        .clk_i    (CLK),
        .rst_i    (RST),
        .clr_i    (!in_req || MEM_ACK),
        .en_i     (in_req && !MEM_ACK),
        .expired_o(expired)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (RUN) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                // Ack beats the timeout when both land in the same cycle.
                if (MEM_ACK)      state_d = ST_DECODE;
                else if (expired) state_d = ST_TRAP;
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                if ((OP_CODE == OP_LOAD) || is_store) state_d = ST_MEM;
                else if (is_wb_op(OP_CODE))           state_d = ST_WB;
                else                                  state_d = ST_TRAP;
            end
            ST_MEM: begin
                if (MEM_ACK) begin
                    if (is_store) state_d = RUN ? ST_FETCH : ST_IDLE;
                    else          state_d = ST_WB;
                end else if (expired) begin
                    state_d = ST_TRAP;
                end
            end
            ST_WB:   state_d = RUN ? ST_FETCH : ST_IDLE;
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        MEM_REQ = 1'b0;
        MEM_SEL = MEM_SEL_PC;
        MEM_WE  = 1'b0;
        IR_LD   = 1'b0;
        PC_WE   = 1'b0;
        RF_WE   = 1'b0;
        FAULT   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                MEM_REQ = 1'b1;
                IR_LD   = MEM_ACK;
            end
            ST_MEM: begin
                MEM_REQ = 1'b1;
                MEM_SEL = MEM_SEL_DATA;
                MEM_WE  = CDM;
                PC_WE   = MEM_ACK && is_store;
            end
            ST_WB: begin
                RF_WE = CRF;
                PC_WE = 1'b1;
            end
            ST_TRAP: FAULT = 1'b1;
            default: ;
        endcase
    end

    // Every retirement coincides with the PC commit.
    always_comb begin
        retired_d = retired_q;
        if (PC_WE) retired_d = retired_q + CNT_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    assign RETIRED = retired_q;

endmodule
